// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU writeback path (requester 0)
// and the memory-load path (requester 1). Each requester has a one-entry buffer,
// and a round-robin arbiter drains one buffered write per cycle.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_adr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_adr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WrAdr,
  output logic [DATA_W-1:0] WrData,
  output logic [NUM_REGS-1:0] pending
);

  logic              full0;
  logic              full1;
  logic [ADDR_W-1:0] adr0;
  logic [ADDR_W-1:0] adr1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              rr;

  logic grant0;
  logic grant1;
  logic xfer0;
  logic xfer1;

  // Grant depends on buffer state only; rr breaks the tie when both are full.
  always_comb begin
    grant0 = full0 && (!full1 || !rr);
    grant1 = full1 && (!full0 || rr);
  end

  // A buffer can accept when empty or when it is being drained this cycle.
  always_comb begin
    req0_ready = !full0 || grant0;
    req1_ready = !full1 || grant1;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
  end

  // Drive the register file write port from the granted buffer.
  always_comb begin
    RegWrite = 1'b0;
    WrAdr    = '0;
    WrData   = '0;
    if (grant0) begin
      RegWrite = 1'b1;
      WrAdr    = adr0;
      WrData   = data0;
    end else if (grant1) begin
      RegWrite = 1'b1;
      WrAdr    = adr1;
      WrData   = data1;
    end
  end

  // Pending bitmap; r0 is never buffered so bit 0 stays clear.
  always_comb begin
    pending = '0;
    for (int unsigned k = 1; k < NUM_REGS; k++) begin
      pending[k] = (full0 && (adr0 == ADDR_W'(k))) || (full1 && (adr1 == ADDR_W'(k)));
    end
  end

  // Buffer load/drain and round-robin pointer; writes to r0 are accepted but dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      adr0  <= '0;
      adr1  <= '0;
      data0 <= '0;
      data1 <= '0;
      rr    <= 1'b0;
    end else begin
      if (xfer0) begin
        full0 <= (req0_adr != '0);
        adr0  <= req0_adr;
        data0 <= req0_data;
      end else if (grant0) begin
        full0 <= 1'b0;
      end

      if (xfer1) begin
        full1 <= (req1_adr != '0);
        adr1  <= req1_adr;
        data1 <= req1_data;
      end else if (grant1) begin
        full1 <= 1'b0;
      end

      if (full0 && full1) begin
        rr <= !rr;
      end
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 8x8 register file between two independent writeback requesters: requester 0 is the ALU result path, requester 1 is the memory-load path. Each requester has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains one buffered write per cycle onto the register file's RegWrite/WrAdr/WrData. A pending-write bitmap is exported for hazard/stall logic.

Parameters:
ADDR_W, 3, register address width
DATA_W, 8, register data width
NUM_REGS, 8, number of registers (= 2**ADDR_W); bit width of pending

Ports:
clk  in  1  clock
rst  in  1  reset
req0_valid  in  1  requester 0 has a write
req0_adr  in  ADDR_W  requester 0 target register
req0_data  in  DATA_W  requester 0 write data
req0_ready  out  1  requester 0 write accepted this cycle when valid
req1_valid  in  1  requester 1 has a write
req1_adr  in  ADDR_W  requester 1 target register
req1_data  in  DATA_W  requester 1 write data
req1_ready  out  1  requester 1 write accepted this cycle when valid
RegWrite  out  1  register file write enable
WrAdr  out  ADDR_W  register file write address
WrData  out  DATA_W  register file write data
pending  out  NUM_REGS  bit k = 1 while a buffered write targets register k

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. Reset clears both buffers (full0=full1=0) and sets the round-robin pointer rr=0 (requester 0 wins the next tie).
- Outputs during and after reset: RegWrite=0, WrAdr=0, WrData=0, pending=0, req0_ready=req1_ready=1.
- Buffer i holds {full_i, adr_i, data_i}. Transfer on requester i occurs when reqi_valid && reqi_ready at a rising clk edge.
- Grant is combinational from buffer state only:
  - Only buffer i full: grant i.
  - Both full: grant rr.
  - Neither full: no grant.
- reqi_ready = !full_i || grant_i. Ready is a function of state only; there is no combinational path from valid to ready.
- Write outputs are combinational from the granted buffer:
  - Grant present: RegWrite=1, WrAdr=adr_g, WrData=data_g.
  - No grant: RegWrite=0, WrAdr=0, WrData=0.
- Register file writes at the next edge; the granted buffer clears at that same edge unless reloaded by a simultaneous transfer.
- Latency: valid accepted at edge N, RegWrite high during cycle N..N+1, register written at edge N+1.
- Throughput: one write per cycle total. A lone requester streams at one write per cycle through the bypass-ready.
- rr update: flips to the other requester only at an edge where both buffers were full (contested grant). It is unchanged otherwise.
- Register 0 writes (adr==0): the handshake completes normally, but the write is discarded. The buffer is not loaded, pending is unchanged, and there is no RegWrite. The register file reads r0 as zero anyway.
- pending[k] = (full0 && adr0==k) || (full1 && adr1==k). pending[0] is always 0.
- Same address in both buffers: both writes are issued in arbitration order; the later-granted value is final. No cross-requester ordering beyond arbitration is guaranteed. Upstream hazard logic uses pending.
- Reset mid-operation: buffered writes are lost without being written, and RegWrite drops immediately (asynchronous).

Test Plan:
1. Assert rst for 2 cycles, then release -> RegWrite=0, WrAdr=0, WrData=0, pending=8'h00, both ready=1.
2. Single write: req0 adr=3, data=8'hA5 for one cycle -> next cycle RegWrite=1, WrAdr=3, WrData=8'hA5, pending=8'h08, req0_ready=1. The following cycle has RegWrite=0 and pending=0, and register 3 reads 8'hA5.
3. Contention: both valid in the same cycle (req0 r1=8'h11, req1 r2=8'h22), then deasserted -> cycle+1 grants req0 with req1_ready=0 and pending=8'h06. Cycle+2 grants req1 with pending=8'h04. Repeating the stimulus grants req1 first.
4. Streaming: req0 valid for 4 consecutive cycles (r4..r7 = 1,2,3,4) with req1 idle -> req0_ready held 1, then RegWrite=1 for 4 consecutive cycles with matching address/data in order.
5. Both requesters streaming continuously -> grants strictly alternate 0,1,0,1. Each ready is 1 only in its granted cycles, and no write is lost or duplicated (compare against a scoreboard).
6. Edge cases: req1 adr=0, data=8'hFF -> req1_ready=1, no RegWrite, pending=0. Separately, with both buffers full, assert rst mid-cycle -> RegWrite=0 and pending=0 immediately, no write reaches the register file, and rr=0 after release.
